// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding the control unit.
// Holds a loadable program store and presents one instruction at a time on
// o_instr. Each word stays on the output for as many clocks as the CU needs
// for its class, then the PC advances. Class 2'b00 is a halt marker: fetch
// stops and o_instr is driven to zero, which keeps the CU in RESET.
module instr_fetch #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5,
  parameter int STD_CYCLES  = 3,
  parameter int MEM_CYCLES  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_stall,
  input  logic                   i_load_we,
  input  logic [PC_BITS-1:0]     i_load_addr,
  input  logic [INSTR_WIDTH-1:0] i_load_data,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [PC_BITS-1:0]     o_pc,
  output logic                   o_instr_valid,
  output logic                   o_halted
);

  localparam int DEPTH    = 2 ** PC_BITS;
  localparam int MAX_HOLD = (STD_CYCLES > MEM_CYCLES) ? STD_CYCLES : MEM_CYCLES;
  localparam int CNT_W    = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // Number of clocks the CU keeps a word of the given class on its input.
  function automatic logic [CNT_W-1:0] hold_of(input logic [1:0] cls);
    return (cls == 2'b01) ? CNT_W'(STD_CYCLES) : CNT_W'(MEM_CYCLES);
  endfunction

  logic [INSTR_WIDTH-1:0] r_mem [DEPTH];

  state_t                 r_state, w_state_next;
  logic [INSTR_WIDTH-1:0] r_instr, w_instr_next;
  logic [PC_BITS-1:0]     r_pc, w_pc_next;
  logic                   r_valid, w_valid_next;
  logic                   r_halted, w_halted_next;
  logic [CNT_W-1:0]       r_cnt, w_cnt_next;

  logic                   w_mem_we;
  logic [PC_BITS-1:0]     w_fetch_addr;
  logic [INSTR_WIDTH-1:0] w_fetch_word;
  logic [1:0]             w_fetch_cls;
  logic                   w_fetch_halt;

  // The store is writable only while fetch is not running.
  assign w_mem_we = i_load_we && (r_state != S_RUN);

  // In RUN the next word is pc+1 (wrapping); otherwise a start fetches word 0.
  assign w_fetch_addr = (r_state == S_RUN) ? (r_pc + PC_BITS'(1)) : '0;
  assign w_fetch_word = r_mem[w_fetch_addr];
  assign w_fetch_cls  = w_fetch_word[INSTR_WIDTH-1:INSTR_WIDTH-2];
  assign w_fetch_halt = (w_fetch_cls == 2'b00);

  // Program store write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[i_load_addr] <= i_load_data;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_instr  <= '0;
      r_pc     <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_instr  <= w_instr_next;
      r_pc     <= w_pc_next;
      r_valid  <= w_valid_next;
      r_halted <= w_halted_next;
      r_cnt    <= w_cnt_next;
    end
  end

  // Next-state logic: start/halt handling and per-word hold counting.
  always_comb begin
    w_state_next  = r_state;
    w_instr_next  = r_instr;
    w_pc_next     = r_pc;
    w_valid_next  = r_valid;
    w_halted_next = r_halted;
    w_cnt_next    = r_cnt;
    case (r_state)
      S_IDLE, S_HALT: begin
        // A load in the same cycle takes priority over start.
        if (i_start && !i_load_we) begin
          w_pc_next = '0;
          if (w_fetch_halt) begin
            w_instr_next  = '0;
            w_valid_next  = 1'b0;
            w_halted_next = 1'b1;
            w_state_next  = S_HALT;
          end else begin
            // Full hold (not hold-1): the CU spends one extra edge leaving RESET.
            w_instr_next  = w_fetch_word;
            w_valid_next  = 1'b1;
            w_halted_next = 1'b0;
            w_cnt_next    = hold_of(w_fetch_cls);
            w_state_next  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!i_stall) begin
          if (r_cnt != '0) begin
            w_cnt_next = r_cnt - CNT_W'(1);
          end else begin
            w_pc_next = w_fetch_addr;
            if (w_fetch_halt) begin
              w_instr_next  = '0;
              w_valid_next  = 1'b0;
              w_halted_next = 1'b1;
              w_state_next  = S_HALT;
            end else begin
              // The fetch edge itself counts as one of the hold clocks.
              w_instr_next = w_fetch_word;
              w_cnt_next   = hold_of(w_fetch_cls) - CNT_W'(1);
            end
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_instr       = r_instr;
  assign o_pc          = r_pc;
  assign o_instr_valid = r_valid;
  assign o_halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: word hold timing, halt, stall,
// PC wrap, load/start gating and asynchronous reset.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_stall;
  logic        i_load_we;
  logic [4:0]  i_load_addr;
  logic [19:0] i_load_data;
  logic [19:0] o_instr;
  logic [4:0]  o_pc;
  logic        o_instr_valid;
  logic        o_halted;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch #(
    .INSTR_WIDTH(20),
    .PC_BITS    (5),
    .STD_CYCLES (3),
    .MEM_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_stall      (i_stall),
    .i_load_we    (i_load_we),
    .i_load_addr  (i_load_addr),
    .i_load_data  (i_load_data),
    .o_instr      (o_instr),
    .o_pc         (o_pc),
    .o_instr_valid(o_instr_valid),
    .o_halted     (o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [4:0] addr, input logic [19:0] data);
    i_load_we   = 1'b1;
    i_load_addr = addr;
    i_load_data = data;
    tick();
    i_load_we   = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Expect a running word for n clocks, checking each one, then step past them.
  task automatic expect_word(input string tag, input logic [19:0] ins,
                             input logic [4:0] pc, input int n);
    for (int k = 0; k < n; k++) begin
      check({tag, ".instr"}, 32'(o_instr), 32'(ins));
      check({tag, ".pc"}, 32'(o_pc), 32'(pc));
      check({tag, ".valid"}, 32'(o_instr_valid), 32'd1);
      check({tag, ".halted"}, 32'(o_halted), 32'd0);
      tick();
    end
    $display("[TB] %s pc=%0d instr=%05h checked %0d clks", tag, pc, ins, n);
  endtask

  task automatic expect_halt(input string tag, input logic [4:0] pc);
    check({tag, ".instr"}, 32'(o_instr), 32'd0);
    check({tag, ".pc"}, 32'(o_pc), 32'(pc));
    check({tag, ".valid"}, 32'(o_instr_valid), 32'd0);
    check({tag, ".halted"}, 32'(o_halted), 32'd1);
    $display("[TB] %s halt at pc=%0d", tag, pc);
  endtask

  initial begin
    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_stall     = 1'b0;
    i_load_we   = 1'b0;
    i_load_addr = '0;
    i_load_data = '0;
    #2;
    // Reset state
    check("rst.instr", 32'(o_instr), 32'd0);
    check("rst.pc", 32'(o_pc), 32'd0);
    check("rst.valid", 32'(o_instr_valid), 32'd0);
    check("rst.halted", 32'(o_halted), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Std + load/store word, then halt
    load_word(5'd0, 20'h4_5A21);
    load_word(5'd1, 20'h8_0143);
    load_word(5'd2, 20'h0_0000);
    check("idle.valid", 32'(o_instr_valid), 32'd0);
    pulse_start();
    expect_word("t2.w0", 20'h4_5A21, 5'd0, 4);
    expect_word("t2.w1", 20'h8_0143, 5'd1, 4);
    expect_halt("t2.end", 5'd2);
    tick();
    expect_halt("t2.stay", 5'd2);

    // Two std words: first gets one extra clock
    load_word(5'd0, 20'h4_1001);
    load_word(5'd1, 20'h4_2002);
    pulse_start();
    expect_word("t3.w0", 20'h4_1001, 5'd0, 4);
    expect_word("t3.w1", 20'h4_2002, 5'd1, 3);
    expect_halt("t3.end", 5'd2);

    // Stall for two clocks during word1
    load_word(5'd0, 20'h4_5A21);
    load_word(5'd1, 20'h4_5A21);
    load_word(5'd2, 20'h4_5A21);
    load_word(5'd3, 20'h0_0000);
    pulse_start();
    expect_word("t4.w0", 20'h4_5A21, 5'd0, 4);
    expect_word("t4.w1a", 20'h4_5A21, 5'd1, 1);
    i_stall = 1'b1;
    expect_word("t4.w1s", 20'h4_5A21, 5'd1, 2);
    i_stall = 1'b0;
    expect_word("t4.w1b", 20'h4_5A21, 5'd1, 2);
    expect_word("t4.w2", 20'h4_5A21, 5'd2, 3);
    expect_halt("t4.end", 5'd3);

    // load_we + start together in HALT: write happens, state stays HALT
    i_load_we   = 1'b1;
    i_start     = 1'b1;
    i_load_addr = 5'd0;
    i_load_data = 20'h8_7777;
    tick();
    i_load_we = 1'b0;
    i_start   = 1'b0;
    expect_halt("t6.both", 5'd3);
    pulse_start();
    expect_word("t6.w0", 20'h8_7777, 5'd0, 5);
    expect_word("t6.w1", 20'h4_5A21, 5'd1, 3);

    // Full store of std words, PC wraps 31 -> 0; RUN ignores load/start
    i_stall = 1'b1;  // park the run while the next program is prepared
    rst_n   = 1'b0;
    #1;
    rst_n   = 1'b1;
    i_stall = 1'b0;
    tick();
    for (int a = 0; a < 32; a++) begin
      load_word(5'(a), 20'h4_0000 | 20'(a));
    end
    pulse_start();
    expect_word("t5.w0", 20'h4_0000, 5'd0, 4);
    i_load_we   = 1'b1;
    i_load_addr = 5'd5;
    i_load_data = 20'h0_0000;
    i_start     = 1'b1;
    expect_word("t6.run", 20'h4_0001, 5'd1, 1);
    i_load_we = 1'b0;
    i_start   = 1'b0;
    expect_word("t5.w1", 20'h4_0001, 5'd1, 2);
    for (int a = 2; a < 32; a++) begin
      expect_word("t5.wn", 20'h4_0000 | 20'(a), 5'(a), 3);
    end
    expect_word("t5.wrap", 20'h4_0000, 5'd0, 3);
    expect_word("t5.w1b", 20'h4_0001, 5'd1, 1);

    // Asynchronous reset mid-RUN, no clock edge in between
    #2;
    rst_n = 1'b0;
    #1;
    check("t1.instr", 32'(o_instr), 32'd0);
    check("t1.pc", 32'(o_pc), 32'd0);
    check("t1.valid", 32'(o_instr_valid), 32'd0);
    check("t1.halted", 32'(o_halted), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t1.idle", 32'(o_instr), 32'd0);

    // Program store survives reset
    pulse_start();
    expect_word("t1.keep", 20'h4_0000, 5'd0, 4);
    expect_word("t1.keep1", 20'h4_0001, 5'd1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
